// File: rtl/nios1_pio_pkg.sv
// Shared constants for the key-input PIO: register word addresses and edge-type codes.
// Latency: none (constants and pure functions only).
// Backpressure: none; the Avalon-MM slave never stalls.
package nios1_pio_pkg;

    // Avalon-MM word addresses of the software-visible registers.
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;

    // Edge-type selector codes for the EDGE_TYPE parameter.
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    typedef logic [2:0]  addr_t;
    typedef logic [31:0] word_t;

    // Width of a debounce counter that can hold 0..cycles without wrapping.
    // A bypassed debouncer still reports a 1-bit width so vector widths stay legal.
    function automatic int debounce_cnt_width(input int cycles);
        if (cycles <= 0) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/nios1_pio_key_in_if.sv
// Avalon-MM slave bus bundle for the key-input PIO (address, strobes, data).
// Latency: reads are combinational (latency 0); writes take effect on the next clk edge.
// Backpressure: none; there is no waitrequest, every access completes immediately.
interface nios1_pio_key_in_if;
    import nios1_pio_pkg::*;

    addr_t address;
    logic  chipselect;
    logic  write_n;
    word_t writedata;
    word_t readdata;

    // Host side: drives the access, samples read data.
    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    // PIO side: decodes the access, returns read data.
    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input pin: 2-flop synchronizer followed by an optional stable-for-N-cycles filter.
// Latency: 2 cycles to sync2; stable follows 1 cycle later (bypass) or after N matching cycles.
// Backpressure: none; the pin is sampled every cycle.
module pio_debounce_bit
    import nios1_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable
);

    logic sync1;
    logic sync2;

    // Two-stage synchronizer: the raw pin is asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass

            // No filtering: stable simply tracks the synchronized pin.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stable <= RESET_VAL;
                end else begin
                    stable <= sync2;
                end
            end

        end else begin : g_filter

            localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;

            // Count consecutive cycles of disagreement; accept the new level on the
            // N-th one. Any agreeing cycle restarts the count, so glitches are dropped
            // and the counter tops out at N-1 (it cannot wrap).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt    <= '0;
                    stable <= RESET_VAL;
                end else if (sync2 == stable) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt    <= '0;
                    stable <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

        end
    endgenerate

endmodule

// File: rtl/nios1_pio_key_in.sv
// Key-input PIO: synchronized/debounced pins, edge capture with write-1-to-clear, masked level irq.
// Latency: bypass pin change -> data after 2 edges, edgecapture after 3; reads are combinational.
// Backpressure: none; Avalon-MM slave with no waitrequest, accesses always complete.
module nios1_pio_key_in
    import nios1_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IN_RESET_VAL    = '1
) (
    input  logic                   clk,
    input  logic                   reset,
    nios1_pio_key_in_if.slave      bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr_mask;
    logic             wr_en;
    logic             unused_wdata_hi;

    // Per-pin synchronizer and debounce filter.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (IN_RESET_VAL[i])
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .pin    (in_port[i]),
            .stable (stable[i])
        );
    end

    // One-cycle history of the filtered pins for edge detection. Resetting it to the
    // same idle level as stable keeps reset release from looking like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d <= IN_RESET_VAL;
        end else begin
            stable_d <= stable;
        end
    end

    // Edge polarity is fixed at build time.
    generate
        if (EDGE_TYPE == EDGE_RISING) begin : g_rise
            assign edge_det = stable & ~stable_d;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_det = stable ^ stable_d;
        end else begin : g_fall
            assign edge_det = ~stable & stable_d;
        end
    endgenerate

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Only the low WIDTH bits of writedata reach any register.
    assign unused_wdata_hi = ^(bus.writedata >> WIDTH);

    // Write-1-to-clear mask for edgecapture; zero unless edgecapture is being written.
    always_comb begin
        clr_mask = '0;
        if (wr_en && (bus.address == ADDR_EDGECAP)) begin
            clr_mask = bus.writedata[WIDTH-1:0];
        end
    end

    // Interrupt mask register; writes to any other address leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && (bus.address == ADDR_IRQMASK)) begin
            irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Sticky edge flags: clear is applied first so a same-cycle edge re-sets the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clr_mask) | edge_det;
        end
    end

    // Zero-latency read mux, decoded from address alone; unmapped words read 0.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata[WIDTH-1:0] = stable;
            ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecapture;
            default:      bus.readdata = '0;
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios1_pio_key_in.sv
// Directed bench for the key-input PIO: a bypass instance and an 8-cycle debounce instance.
// Latency: checks the bypass 2/3-edge pin-to-data/edgecapture timing and the debounce threshold.
// Backpressure: not applicable; bus accesses complete in one cycle.
module tb_nios1_pio_key_in;
    import nios1_pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pin0;
    logic [3:0] pin8;
    logic       irq0;
    logic       irq8;

    int checks = 0;
    int errors = 0;

    nios1_pio_key_in_if b0 ();
    nios1_pio_key_in_if b8 ();

    nios1_pio_key_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1), .IN_RESET_VAL(4'hF)
    ) u_dut0 (
        .clk(clk), .reset(reset), .bus(b0), .in_port(pin0), .irq(irq0)
    );

    nios1_pio_key_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1), .IN_RESET_VAL(4'hF)
    ) u_dut8 (
        .clk(clk), .reset(reset), .bus(b8), .in_port(pin8), .irq(irq8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        b0.chipselect = 1'b0; b0.write_n = 1'b1; b0.address = 3'd0; b0.writedata = '0;
        b8.chipselect = 1'b0; b8.write_n = 1'b1; b8.address = 3'd0; b8.writedata = '0;
    endtask

    // Single write cycle; the register updates on the edge this task waits for.
    task automatic bus_wr(input bit d8, input logic [2:0] a, input logic [31:0] d);
        if (d8) begin
            b8.address = a; b8.writedata = d; b8.chipselect = 1'b1; b8.write_n = 1'b0;
        end else begin
            b0.address = a; b0.writedata = d; b0.chipselect = 1'b1; b0.write_n = 1'b0;
        end
        tick(1);
        bus_idle();
    endtask

    // Combinational read between clock edges, compared against the expected word.
    task automatic rd_chk(input bit d8, input logic [2:0] a, input string tag,
                          input logic [31:0] exp);
        logic [31:0] q;
        if (d8) begin
            b8.address = a; b8.chipselect = 1'b1; b8.write_n = 1'b1;
        end else begin
            b0.address = a; b0.chipselect = 1'b1; b0.write_n = 1'b1;
        end
        #1;
        q = d8 ? b8.readdata : b0.readdata;
        bus_idle();
        check(tag, q, exp);
    endtask

    initial begin
        reset = 1'b1;
        pin0  = 4'hF;
        pin8  = 4'hF;
        bus_idle();
        #2;

        // Reset state of both instances.
        rd_chk(0, ADDR_DATA,    "rst0_data",  32'hF);
        rd_chk(0, ADDR_IRQMASK, "rst0_mask",  32'h0);
        rd_chk(0, ADDR_EDGECAP, "rst0_ecap",  32'h0);
        check("rst0_irq", {31'd0, irq0}, 32'h0);
        rd_chk(1, ADDR_DATA,    "rst8_data",  32'hF);
        rd_chk(1, ADDR_EDGECAP, "rst8_ecap",  32'h0);
        tick(2);
        reset = 1'b0;
        tick(3);
        rd_chk(0, ADDR_EDGECAP, "release0_ecap", 32'h0);

        // Bypass latency: pin change sampled at edge k.
        pin0 = 4'hE;
        tick(1);                                   // edge k
        tick(1);                                   // edge k+1
        rd_chk(0, ADDR_DATA,    "byp_data_k1", 32'hF);
        tick(1);                                   // edge k+2
        rd_chk(0, ADDR_DATA,    "byp_data_k2", 32'hE);
        rd_chk(0, ADDR_EDGECAP, "byp_ecap_k2", 32'h0);
        tick(1);                                   // edge k+3
        rd_chk(0, ADDR_EDGECAP, "byp_ecap_k3", 32'h1);
        check("byp_irq_unmasked", {31'd0, irq0}, 32'h0);

        bus_wr(0, ADDR_IRQMASK, 32'h1);
        rd_chk(0, ADDR_IRQMASK, "mask_rb", 32'h1);
        check("irq_masked_on", {31'd0, irq0}, 32'h1);

        // Writes to read-only / unmapped addresses change nothing.
        bus_wr(0, 3'd0, 32'hFFFF_FFFF);
        bus_wr(0, 3'd1, 32'hFFFF_FFFF);
        bus_wr(0, 3'd5, 32'hFFFF_FFFF);
        rd_chk(0, ADDR_DATA,    "ignwr_data", 32'hE);
        rd_chk(0, ADDR_IRQMASK, "ignwr_mask", 32'h1);
        rd_chk(0, ADDR_EDGECAP, "ignwr_ecap", 32'h1);
        rd_chk(0, 3'd1, "rd_addr1", 32'h0);
        rd_chk(0, 3'd7, "rd_addr7", 32'h0);

        // Write-1-to-clear: writing 0 leaves the flag, writing 1 clears it.
        bus_wr(0, ADDR_EDGECAP, 32'h0);
        check("w0_irq_stays", {31'd0, irq0}, 32'h1);
        rd_chk(0, ADDR_EDGECAP, "w0_ecap", 32'h1);
        bus_wr(0, ADDR_EDGECAP, 32'h1);
        check("w1_irq_clear", {31'd0, irq0}, 32'h0);
        rd_chk(0, ADDR_EDGECAP, "w1_ecap", 32'h0);

        // Edge on bit1 lands on the same edge as a clear of bit1: set wins.
        pin0 = 4'hC;
        tick(3);                                   // through edge k+2
        rd_chk(0, ADDR_EDGECAP, "race_pre", 32'h0);
        bus_wr(0, ADDR_EDGECAP, 32'h2);            // edge k+3
        rd_chk(0, ADDR_EDGECAP, "race_setwins", 32'h2);
        check("race_irq", {31'd0, irq0}, 32'h0);
        bus_wr(0, ADDR_EDGECAP, 32'h2);
        rd_chk(0, ADDR_EDGECAP, "race_clear", 32'h0);

        // Debounce 8: a 7-cycle low pulse on bit0 is rejected.
        pin8 = 4'hE;
        tick(7);
        pin8 = 4'hF;
        tick(12);
        rd_chk(1, ADDR_DATA,    "db7_data", 32'hF);
        rd_chk(1, ADDR_EDGECAP, "db7_ecap", 32'h0);

        // An 8-cycle low level is accepted: stable on edge 10, capture on edge 11.
        pin8 = 4'hE;
        tick(9);
        rd_chk(1, ADDR_DATA, "db8_data_e9", 32'hF);
        tick(1);
        rd_chk(1, ADDR_DATA,    "db8_data_e10", 32'hE);
        rd_chk(1, ADDR_EDGECAP, "db8_ecap_e10", 32'h0);
        tick(1);
        rd_chk(1, ADDR_EDGECAP, "db8_ecap_e11", 32'h1);

        // Load all flags and mask, then reset with a count in progress.
        pin8 = 4'h0;
        tick(12);
        bus_wr(1, ADDR_IRQMASK, 32'hF);
        rd_chk(1, ADDR_EDGECAP, "pre_rst_ecap", 32'hF);
        check("pre_rst_irq", {31'd0, irq8}, 32'h1);
        pin8 = 4'hF;
        tick(12);
        rd_chk(1, ADDR_DATA, "pre_rst_data", 32'hF);
        pin8 = 4'hE;
        tick(5);
        reset = 1'b1;
        #1;
        check("inrst_irq", {31'd0, irq8}, 32'h0);
        rd_chk(1, ADDR_IRQMASK, "inrst_mask", 32'h0);
        rd_chk(1, ADDR_EDGECAP, "inrst_ecap", 32'h0);
        rd_chk(1, ADDR_DATA,    "inrst_data", 32'hF);
        rd_chk(0, ADDR_IRQMASK, "inrst_mask0", 32'h0);
        tick(2);
        pin8  = 4'hF;
        reset = 1'b0;
        tick(12);
        rd_chk(1, ADDR_EDGECAP, "postrst_ecap", 32'h0);
        rd_chk(1, ADDR_DATA,    "postrst_data", 32'hF);
        check("postrst_irq", {31'd0, irq8}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios1_pio_key_in.md
NIOS1_PIO_KEY_IN -- requirements
Module: nios1_pio_key_in

Interface
REQ-001 Parameter WIDTH, default 4: number of input pins.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a pin change; 0 bypasses debouncing.
REQ-003 Parameter EDGE_TYPE, default 1: 0 = rising, 1 = falling, 2 = any edge captured.
REQ-004 Parameter IN_RESET_VAL, default all ones: reset value of the synchronizer and stable registers (idle level of active-low keys).
REQ-005 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-006 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 address  input  3  Avalon-MM slave word address.
REQ-009 chipselect  input  1  slave select.
REQ-010 write_n  input  1  active-low write strobe.
REQ-011 writedata  input  32  write data.
REQ-012 readdata  output  32  read data, zero-extended, read latency 0.
REQ-013 in_port  input  WIDTH  asynchronous external pins.
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 in_port SHALL pass through a 2-flop synchronizer per bit (sync1, then sync2) before any other use.
REQ-016 DEBOUNCE_CYCLES=0: stable SHALL be loaded from sync2 every cycle.
REQ-017 DEBOUNCE_CYCLES>0: a per-bit counter SHALL increment each cycle that sync2 differs from stable, and clear to 0 in any cycle where they match.
REQ-018 When a bit's counter reaches DEBOUNCE_CYCLES-1 and sync2 still differs, stable SHALL take sync2 on that edge and the counter SHALL clear; a change held for exactly DEBOUNCE_CYCLES cycles is accepted, and one held fewer is ignored.
REQ-019 The counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-020 stable_d SHALL hold stable delayed by one cycle. An edge SHALL be: rising = stable & ~stable_d; falling = ~stable & stable_d; any = stable ^ stable_d, selected by EDGE_TYPE.
REQ-021 Register map (word address): 0 = data (RO, stable zero-extended); 2 = irqmask (RW, WIDTH bits); 3 = edgecapture (R, write-1-to-clear).
REQ-022 Write strobe = chipselect & ~write_n; writes to addresses 0, 1, 4-7 SHALL be ignored.
REQ-023 Reads from addresses 1 and 4-7 SHALL return 0; readdata SHALL be a combinational mux of address, independent of chipselect.
REQ-024 An edgecapture bit SHALL set on a detected edge and hold until cleared by writing 1 to that bit at address 3; writing 0 SHALL leave the bit unchanged.
REQ-025 If an edge and a clear of the same bit occur in the same cycle, set SHALL win.
REQ-026 irq SHALL be |(edgecapture & irqmask), combinational from the registers with no added latency.
REQ-027 Latency with bypass: a pin change sampled at edge k SHALL appear in stable at edge k+2 and in edgecapture at edge k+3.

Reset
REQ-028 On reset: sync1, sync2, stable and stable_d SHALL load IN_RESET_VAL; counters, irqmask and edgecapture SHALL load 0; irq SHALL be 0.
REQ-029 Reset asserted mid-debounce SHALL discard partial counts, and no edge SHALL be captured on reset release while the pins are at IN_RESET_VAL.

Structure
REQ-030 Shared package nios1_pio_pkg SHALL hold the address constants (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and the EDGE_RISING/FALLING/ANY constants.
REQ-031 The per-bit synchronizer, counter and stable register SHALL be a sub-module, pio_debounce_bit, instantiated WIDTH times.

Verification
REQ-032 Bypass, EDGE_TYPE=1, in_port 4'hF->4'hE at edge k: read address 0 returns 0x0000000E from edge k+2; edgecapture reads 0x1 from edge k+3; irq stays 0 with irqmask=0.
REQ-033 DEBOUNCE_CYCLES=8: bit0 low for 7 cycles then high -> data and edgecapture unchanged; bit0 low for 8 cycles -> data bit0=0 and edgecapture bit0=1.
REQ-034 irqmask=0x1 and edgecapture=0x1 -> irq=1; write 0x1 to address 3 -> irq=0 the next cycle; write 0x0 instead -> irq stays 1.
REQ-035 A new falling edge on bit1 in the same cycle as a write of 0x2 to address 3 -> edgecapture bit1 stays 1.
REQ-036 Assert reset with edgecapture=0xF, irqmask=0xF and a debounce count in progress -> all read 0, irq=0; release with in_port=4'hF -> no capture.
REQ-037 Writes to addresses 0, 1 and 5 -> no register change; reads of addresses 1 and 7 return 0x00000000.
